// File: rtl/dmem_store_buffer.sv
// Store buffer between the MEM stage and the data memory port: queues stores,
// drains them in load-free cycles, and forwards the youngest matching store to loads.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          mem_clk,
    input  logic          reset,
    input  logic          ld_req,
    input  logic          st_req,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] st_data,
    output logic          stall,
    output logic          ld_valid,
    output logic [DW-1:0] ld_data,
    output logic          empty,
    output logic          dwe,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] entryAddr_q [DEPTH];
    logic [DW-1:0] entryData_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ldValid_q;
    logic          hit_q;
    logic [DW-1:0] fwd_q;

    logic          full;
    logic          drain;
    logic          push;
    logic          hit;
    logic [DW-1:0] fwdData;
    logic [PW-1:0] idx;

    // Walk entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit     = 1'b0;
        fwdData = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (entryAddr_q[idx] == req_addr)) begin
                hit     = 1'b1;
                fwdData = entryData_q[idx];
            end
        end
    end

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        drain   = !ld_req && !empty;
        push    = st_req && !ld_req && (!full || drain);
        stall   = st_req && (ld_req || (full && !drain));
        dwe     = drain;
        addr    = '0;
        wdata   = '0;
        if (ld_req) begin
            addr = req_addr;
        end else if (drain) begin
            addr  = entryAddr_q[head_q];
            wdata = entryData_q[head_q];
        end
        head_d  = drain ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, drain};
    end

    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr_q[i] <= '0;
                entryData_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                entryAddr_q[tail_q] <= req_addr;
                entryData_q[tail_q] <= st_data;
            end
        end
    end

    // Forwarded data is captured at the request edge; misses take rdata next cycle.
    always_ff @(posedge mem_clk or posedge reset) begin
        if (reset) begin
            ldValid_q <= 1'b0;
            hit_q     <= 1'b0;
            fwd_q     <= '0;
        end else begin
            ldValid_q <= ld_req;
            hit_q     <= ld_req && hit;
            if (ld_req && hit) begin
                fwd_q <= fwdData;
            end
        end
    end

    assign ld_valid = ldValid_q;
    assign ld_data  = ldValid_q ? (hit_q ? fwd_q : rdata) : '0;

endmodule
